// File: rtl/boot_rom_bus_ctrl.sv
// CPU-side responder for the 256-byte boot PROM overlay, the sticky boot-disable latch
// and cartridge bus forwarding with a bounded wait for cart_ack.
module boot_rom_bus_ctrl #(
  parameter int          BOOT_SIZE    = 256,
  parameter logic [15:0] DISABLE_ADDR = 16'hFF50,
  parameter int          CART_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ack,
  output logic        boot_en,
  output logic        timeout_err,
  output logic        prom_ce,
  output logic        prom_oce,
  output logic [7:0]  prom_ad,
  input  logic [7:0]  prom_dout,
  output logic        cart_req,
  output logic        cart_we,
  output logic [15:0] cart_addr,
  output logic [7:0]  cart_wdata,
  input  logic [7:0]  cart_rdata,
  input  logic        cart_ack
);

  typedef enum logic [1:0] {IDLE, PROM_DATA, CART_WAIT, DONE} state_t;

  localparam logic [16:0] BOOT_LIMIT   = 17'(BOOT_SIZE);
  localparam logic [7:0]  TIMEOUT_LOAD = 8'(CART_TIMEOUT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       boot_hit;
  logic       dis_hit;

  assign boot_hit = boot_en & ~we & ({1'b0, addr} < BOOT_LIMIT);
  assign dis_hit  = (addr == DISABLE_ADDR);
  assign prom_oce = 1'b1;

  // The PROM address must be presented in the decode cycle itself so its registered
  // output is ready one cycle later; gating with reset keeps it quiet while held in reset.
  // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
  always_comb begin
    prom_ce = 1'b0;
    prom_ad = 8'h00;
    if (!reset && state == IDLE && req && boot_hit) begin
      prom_ce = 1'b1;
      prom_ad = addr[7:0];
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 8'h00;
      rdata       <= 8'h00;
      ack         <= 1'b0;
      boot_en     <= 1'b1;
      timeout_err <= 1'b0;
      cart_req    <= 1'b0;
      cart_we     <= 1'b0;
      cart_addr   <= 16'h0000;
      cart_wdata  <= 8'h00;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (boot_hit) begin
              state <= PROM_DATA;
            end else if (dis_hit) begin
              if (we && wdata[0]) boot_en <= 1'b0;
              if (!we) rdata <= 8'hFF;
              ack   <= 1'b1;
              state <= DONE;
            end else begin
              cart_req   <= 1'b1;
              cart_we    <= we;
              cart_addr  <= addr;
              cart_wdata <= wdata;
              wait_cnt   <= TIMEOUT_LOAD;
              state      <= CART_WAIT;
            end
          end
        end
        PROM_DATA: begin
          rdata <= prom_dout;
          ack   <= 1'b1;
          state <= DONE;
        end
        CART_WAIT: begin
          // A cart_ack landing in the same cycle as expiry still completes normally.
          if (cart_ack) begin
            cart_req <= 1'b0;
            if (!cart_we) rdata <= cart_rdata;
            ack   <= 1'b1;
            state <= DONE;
          end else if (wait_cnt == 8'h00) begin
            cart_req    <= 1'b0;
            rdata       <= 8'hFF;
            timeout_err <= 1'b1;
            ack         <= 1'b1;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 8'h01;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_rom_bus_ctrl.sv
// Self-checking bench for boot_rom_bus_ctrl: transaction-level model predicts latency,
// read data and sticky flags; one negedge process compares the DUT every cycle.
module tb_boot_rom_bus_ctrl;

  localparam int CT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic        ack;
  logic        boot_en;
  logic        timeout_err;
  logic        prom_ce;
  logic        prom_oce;
  logic [7:0]  prom_ad;
  logic [7:0]  prom_dout = 8'h00;
  logic        cart_req;
  logic        cart_we;
  logic [15:0] cart_addr;
  logic [7:0]  cart_wdata;
  logic [7:0]  cart_rdata = 8'h00;
  logic        cart_ack = 1'b0;

  boot_rom_bus_ctrl #(
    .BOOT_SIZE   (256),
    .DISABLE_ADDR(16'hFF50),
    .CART_TIMEOUT(CT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ack        (ack),
    .boot_en    (boot_en),
    .timeout_err(timeout_err),
    .prom_ce    (prom_ce),
    .prom_oce   (prom_oce),
    .prom_ad    (prom_ad),
    .prom_dout  (prom_dout),
    .cart_req   (cart_req),
    .cart_we    (cart_we),
    .cart_addr  (cart_addr),
    .cart_wdata (cart_wdata),
    .cart_rdata (cart_rdata),
    .cart_ack   (cart_ack)
  );

  always #5 clk = ~clk;

  // PROM contents and its one-cycle registered read port
  logic [7:0] prom_mem [256];
  always @(posedge clk) if (prom_ce) prom_dout <= prom_mem[prom_ad];

  int   cyc = 0;
  logic rst_q = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Architectural state of the model, updated once per completed transaction
  logic       m_boot_en = 1'b1;
  logic       m_tout = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  // Expectations for the transaction in flight
  logic        active = 1'b0;
  logic        e_prom = 1'b0;
  logic        e_cart = 1'b0;
  int          t0 = 0;
  int          e_ack_cyc = 0;
  int          e_cart_end = 0;
  logic [7:0]  e_rdata = 8'h00;
  logic        e_boot_new = 1'b1;
  logic        e_tout_new = 1'b0;
  logic        e_we = 1'b0;
  logic [15:0] e_addr = 16'h0000;
  logic [7:0]  e_wdata = 8'h00;

  // Observations used by the hand-computed literal checks
  logic [7:0] last_rdata = 8'h00;
  logic [7:0] last_prom_ad = 8'h00;
  int         last_lat = 0;
  logic       prom_seen = 1'b0;
  logic       cart_seen = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      // outputs are not defined until the reset edge has been taken
    end else if (rst_q) begin
      check("rst_ack", ack, 1'b0);
      check("rst_cart_req", cart_req, 1'b0);
      check("rst_boot_en", boot_en, 1'b1);
      check("rst_timeout_err", timeout_err, 1'b0);
      check("rst_rdata", rdata, 8'h00);
      check("rst_cart_we", cart_we, 1'b0);
      check("rst_cart_addr", cart_addr, 16'h0000);
      check("rst_cart_wdata", cart_wdata, 8'h00);
      check("rst_prom_oce", prom_oce, 1'b1);
    end else if (active) begin
      check("ack", ack, cyc == e_ack_cyc);
      check("prom_ce", prom_ce, e_prom && cyc == t0);
      if (prom_ce) prom_seen = 1'b1;
      if (e_prom && cyc == t0) begin
        check("prom_ad", prom_ad, e_addr[7:0]);
        last_prom_ad = prom_ad;
      end
      check("cart_req", cart_req, e_cart && cyc > t0 && cyc <= e_cart_end);
      if (cart_req) cart_seen = 1'b1;
      if (e_cart && cyc > t0 && cyc <= e_cart_end) begin
        check("cart_we", cart_we, e_we);
        check("cart_addr", cart_addr, e_addr);
        check("cart_wdata", cart_wdata, e_wdata);
      end
      check("rdata", rdata, (cyc >= e_ack_cyc) ? e_rdata : m_rdata);
      check("boot_en", boot_en, (cyc >= e_ack_cyc) ? e_boot_new : m_boot_en);
      check("timeout_err", timeout_err, (cyc >= e_ack_cyc) ? e_tout_new : m_tout);
      check("prom_oce", prom_oce, 1'b1);
      if (ack) begin
        last_rdata = rdata;
        last_lat   = cyc - t0;
      end
    end else begin
      check("idle_ack", ack, 1'b0);
      check("idle_cart_req", cart_req, 1'b0);
      check("idle_prom_ce", prom_ce, 1'b0);
      check("idle_rdata", rdata, m_rdata);
      check("idle_boot_en", boot_en, m_boot_en);
      check("idle_timeout_err", timeout_err, m_tout);
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic do_reset(input int k);
    reset    = 1'b1;
    req      = 1'b0;
    cart_ack = 1'b0;
    repeat (k) begin
      @(posedge clk); #1;
    end
    reset     = 1'b0;
    m_boot_en = 1'b1;
    m_tout    = 1'b0;
    m_rdata   = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int g);
    req = 1'b0;
    we  = 1'b0;
    for (int i = 0; i < g; i++) begin
      cart_ack   = ($urandom_range(0, 2) == 0);
      cart_rdata = 8'($urandom);
      @(posedge clk); #1;
    end
    cart_ack = 1'b0;
  endtask

  // n: cycles after cart_req rises that cart_ack is pulsed (-1 = never)
  // abort: cycles after req at which reset is asserted (-1 = never)
  task automatic do_txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                        input int n, input logic [7:0] cdata, input int abort);
    logic bh;
    logic dh;
    logic accepted;
    int   off;
    int   lat;
    bh = m_boot_en && !w && (a < 16'd256);
    dh = (a == 16'hFF50);
    e_prom     = bh;
    e_cart     = !bh && !dh;
    e_boot_new = m_boot_en;
    e_tout_new = m_tout;
    e_rdata    = m_rdata;
    e_we       = w;
    e_addr     = a;
    e_wdata    = d;
    t0         = cyc;
    e_cart_end = t0;
    if (bh) begin
      lat     = 2;
      e_rdata = prom_mem[a[7:0]];
    end else if (dh) begin
      lat = 1;
      if (w) begin
        if (d[0]) e_boot_new = 1'b0;
      end else begin
        e_rdata = 8'hFF;
      end
    end else begin
      // The responder waits through CT+1 cycles of cart_req before giving up.
      accepted   = (n >= 0) && (n <= CT);
      off        = accepted ? n : CT;
      lat        = off + 2;
      e_cart_end = t0 + 1 + off;
      if (accepted) begin
        if (!w) e_rdata = cdata;
      end else begin
        e_rdata    = 8'hFF;
        e_tout_new = 1'b1;
      end
    end
    e_ack_cyc  = t0 + lat;
    req        = 1'b1;
    we         = w;
    addr       = a;
    wdata      = d;
    cart_rdata = cdata;
    cart_ack   = 1'b0;
    active     = 1'b1;
    for (int i = 0; i < lat + 1; i++) begin
      @(posedge clk); #1;
      if (abort >= 0 && cyc == t0 + abort) begin
        active = 1'b0;
        do_reset(1);
        return;
      end
      cart_ack = e_cart && (n >= 1) && (cyc == t0 + 1 + n);
    end
    active    = 1'b0;
    cart_ack  = 1'b0;
    m_boot_en = e_boot_new;
    m_tout    = e_tout_new;
    m_rdata   = e_rdata;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) prom_mem[i] = 8'($urandom);
    prom_mem[0]   = 8'h31;
    prom_mem[1]   = 8'hA5;
    prom_mem[255] = 8'h50;

    do_reset(3);

    // PROM reads from reset
    prom_seen = 1'b0;
    cart_seen = 1'b0;
    do_txn(1'b0, 16'h0000, 8'h00, -1, 8'h00, -1);
    check("t1_rdata_0000", last_rdata, 8'h31);
    check("t1_lat_0000", last_lat, 2);
    check("t1_prom_ad_0000", last_prom_ad, 8'h00);
    do_txn(1'b0, 16'h00FF, 8'h00, -1, 8'h00, -1);
    check("t1_rdata_00ff", last_rdata, 8'h50);
    check("t1_lat_00ff", last_lat, 2);
    check("t1_prom_ad_00ff", last_prom_ad, 8'hFF);
    idle(1);
    check("t1_no_cart_req", cart_seen, 1'b0);

    // Disable overlay, then 0x0000 goes to the cart
    do_txn(1'b1, 16'hFF50, 8'h01, -1, 8'h00, -1);
    check("t2_lat_disable", last_lat, 1);
    check("t2_boot_en", boot_en, 1'b0);
    cart_seen = 1'b0;
    do_txn(1'b0, 16'h0000, 8'h00, 3, 8'hC3, -1);
    check("t2_cart_req_seen", cart_seen, 1'b1);
    check("t2_rdata", last_rdata, 8'hC3);
    check("t2_lat", last_lat, 5);
    idle(2);
    do_reset(2);

    // FF50 write of 0 keeps overlay; FF50 read returns FF
    cart_seen = 1'b0;
    do_txn(1'b1, 16'hFF50, 8'h00, -1, 8'h00, -1);
    check("t3_boot_en", boot_en, 1'b1);
    do_txn(1'b0, 16'hFF50, 8'h00, -1, 8'h00, -1);
    check("t3_rdata", last_rdata, 8'hFF);
    check("t3_lat", last_lat, 1);
    check("t3_no_cart_req", cart_seen, 1'b0);
    idle(1);

    // Write into the PROM window is forwarded to the cart
    prom_seen = 1'b0;
    cart_seen = 1'b0;
    do_txn(1'b1, 16'h0010, 8'h5A, 2, 8'h00, -1);
    check("t4_cart_seen", cart_seen, 1'b1);
    check("t4_prom_ce_quiet", prom_seen, 1'b0);
    check("t4_cart_we", cart_we, 1'b1);
    check("t4_cart_addr", cart_addr, 16'h0010);
    check("t4_cart_wdata", cart_wdata, 8'h5A);
    check("t4_lat", last_lat, 4);
    idle(1);

    // Cart timeout, then PROM still readable
    do_txn(1'b0, 16'h4000, 8'h00, -1, 8'h77, -1);
    check("t5_rdata", last_rdata, 8'hFF);
    check("t5_timeout_err", timeout_err, 1'b1);
    check("t5_lat", last_lat, CT + 2);
    do_txn(1'b0, 16'h0001, 8'h00, -1, 8'h00, -1);
    check("t5_prom_after", last_rdata, 8'hA5);
    idle(1);

    // Reset in CART_WAIT after a disable
    do_txn(1'b1, 16'hFF50, 8'h01, -1, 8'h00, -1);
    do_txn(1'b0, 16'h0000, 8'h00, -1, 8'h00, 2);
    check("t6_boot_en", boot_en, 1'b1);
    do_txn(1'b0, 16'h0000, 8'h00, -1, 8'h00, -1);
    check("t6_rdata", last_rdata, 8'h31);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      int          sel;
      if ($urandom_range(0, 39) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        sel = $urandom_range(0, 3);
        if (sel == 0)      a = 16'($urandom_range(0, 255));
        else if (sel == 1) a = 16'hFF50;
        else               a = 16'($urandom);
        do_txn(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(1, CT + 2),
               8'($urandom), -1);
        idle($urandom_range(0, 2));
      end
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
